// File: rtl/hqm_aw_rf_pg_banked.sv
// Power-gated N-bank register file with an on-block sequencer that releases bank power one bank at a time.
// Optional parity on the spare macro bit is enabled by defining HQM_AW_RF_PG_PARITY_EN.
module hqm_aw_rf_pg_banked #(
  parameter int DEPTH       = 2048,
  parameter int WIDTH       = 25,
  parameter int NUM_BANKS   = 2,
  parameter int MACRO_WIDTH = 26,
  parameter int PWR_STAGGER = 4
) (
  input  logic                     rclk,
  input  logic                     rclk_rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rdata_v,
  input  logic                     pwr_req,
  output logic                     pwr_ack,
  output logic                     err_access_off,
  output logic                     par_err,
  input  logic                     pgcb_isol_en,
  input  logic                     pwr_enable_b_in,
  output logic                     pwr_enable_b_out,
  input  logic                     ip_reset_b,
  input  logic                     fscan_byprst_b,
  input  logic                     fscan_rstbypen,
  input  logic                     fscan_clkungate
);

  localparam int AW         = $clog2(DEPTH);
  localparam int BANK_DEPTH = DEPTH / NUM_BANKS;
  localparam int BW         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int LAW        = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int WAKE_LEN   = NUM_BANKS * PWR_STAGGER;
  localparam int CW         = $clog2(WAKE_LEN + 1);

  localparam logic [AW:0] DEPTH_W      = (AW+1)'(DEPTH);
  localparam logic [AW:0] BANK_DEPTH_W = (AW+1)'(BANK_DEPTH);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_WAKE  = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;
  localparam logic [1:0] ST_SLEEP = 2'd3;

  // ---------------------------------------------------------------------------
  // Macro reset synchroniser with scan bypass
  // ---------------------------------------------------------------------------
  logic [1:0] ip_rst_sync_reg;
  logic       macro_rst_b;

  always_ff @(posedge rclk or negedge rclk_rst_n) begin
    if (!rclk_rst_n) begin
      ip_rst_sync_reg <= '0;
    end else begin
      ip_rst_sync_reg <= {ip_rst_sync_reg[0], ip_reset_b};
    end
  end

  assign macro_rst_b = fscan_rstbypen ? fscan_byprst_b : ip_rst_sync_reg[1];

  // ---------------------------------------------------------------------------
  // Power sequencer
  // ---------------------------------------------------------------------------
  logic [1:0]           state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [NUM_BANKS-1:0] enable_b_reg, enable_b_next;
  logic [NUM_BANKS-1:0] bank_enable_b;

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    case (state_reg)
      ST_OFF: begin
        if (pwr_req) state_next = ST_WAKE;
      end
      ST_WAKE: begin
        if (!pwr_req) begin
          state_next = ST_SLEEP;
        end else if (cnt_reg == CW'(WAKE_LEN - 1)) begin
          state_next = ST_ON;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_ON: begin
        if (!pwr_req) state_next = ST_SLEEP;
      end
      default: begin
        state_next = ST_OFF;
      end
    endcase
  end

  // Enables are registered from the next state so each release edge is glitch-free toward the PGCB.
  always_comb begin
    enable_b_next = '1;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (state_next == ST_ON ||
          (state_next == ST_WAKE && cnt_next >= CW'(k * PWR_STAGGER))) begin
        enable_b_next[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge rclk or negedge rclk_rst_n) begin
    if (!rclk_rst_n) begin
      state_reg    <= ST_OFF;
      cnt_reg      <= '0;
      enable_b_reg <= '1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      enable_b_reg <= enable_b_next;
    end
  end

  assign pwr_ack = (state_reg == ST_ON);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_chain
      if (gi == 0) begin : g_first
        assign bank_enable_b[gi] = enable_b_reg[gi] | pwr_enable_b_in;
      end else begin : g_next
        assign bank_enable_b[gi] = enable_b_reg[gi] | bank_enable_b[gi-1];
      end
    end
  endgenerate

  assign pwr_enable_b_out = bank_enable_b[NUM_BANKS-1];

  // ---------------------------------------------------------------------------
  // Access qualification and bank decode
  // ---------------------------------------------------------------------------
  logic [AW:0]      waddr_x, raddr_x;
  logic [BW-1:0]    wr_bank, rd_bank;
  logic [LAW-1:0]   wr_local, rd_local;
  logic             wr_ok, rd_ok;
  logic [MACRO_WIDTH-1:0] wr_word;

  assign waddr_x  = {1'b0, waddr};
  assign raddr_x  = {1'b0, raddr};
  assign wr_bank  = BW'(waddr_x / BANK_DEPTH_W);
  assign rd_bank  = BW'(raddr_x / BANK_DEPTH_W);
  assign wr_local = LAW'(waddr_x % BANK_DEPTH_W);
  assign rd_local = LAW'(raddr_x % BANK_DEPTH_W);

  assign wr_ok = we & pwr_ack & macro_rst_b & (waddr_x < DEPTH_W);
  assign rd_ok = re & pwr_ack & macro_rst_b & (raddr_x < DEPTH_W);

  always_comb begin
    wr_word             = '0;
    wr_word[WIDTH-1:0]  = wdata;
`ifdef HQM_AW_RF_PG_PARITY_EN
    wr_word[WIDTH]      = ^wdata;
`else
    wr_word[WIDTH]      = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------------
  // Bank arrays: registered read, read-first on a same-address collision
  // ---------------------------------------------------------------------------
  logic [MACRO_WIDTH-1:0] bank_rd [NUM_BANKS];

  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [MACRO_WIDTH-1:0] mem [BANK_DEPTH];
      logic [MACRO_WIDTH-1:0] rd_q;

      always_ff @(posedge rclk) begin
        if (wr_ok && wr_bank == BW'(gi)) begin
          mem[wr_local] <= wr_word;
        end
        if ((rd_ok && rd_bank == BW'(gi)) || fscan_clkungate) begin
          rd_q <= mem[rd_local];
        end
      end

      // Isolated banks present a clamped zero to the output mux.
      assign bank_rd[gi] = pgcb_isol_en ? '0 : rd_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read return, error pulse
  // ---------------------------------------------------------------------------
  logic [BW-1:0]          rd_sel_reg;
  logic                   rd_seen_reg;
  logic                   rdata_v_reg;
  logic                   err_reg;
  logic [MACRO_WIDTH-1:0] rd_word;

  always_ff @(posedge rclk or negedge rclk_rst_n) begin
    if (!rclk_rst_n) begin
      rd_sel_reg  <= '0;
      rd_seen_reg <= 1'b0;
      rdata_v_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      rdata_v_reg <= rd_ok;
      err_reg     <= (we & ~wr_ok) | (re & ~rd_ok);
      if (rd_ok) begin
        rd_sel_reg  <= rd_bank;
        rd_seen_reg <= 1'b1;
      end
    end
  end

  assign rd_word        = bank_rd[rd_sel_reg];
  assign rdata          = rd_seen_reg ? rd_word[WIDTH-1:0] : '0;
  assign rdata_v        = rdata_v_reg;
  assign err_access_off = err_reg;

`ifdef HQM_AW_RF_PG_PARITY_EN
  assign par_err = rdata_v_reg & ((^rd_word[WIDTH-1:0]) ^ rd_word[WIDTH]);
  if (MACRO_WIDTH > WIDTH + 1) begin : g_pad
    logic spare_unused;
    assign spare_unused = ^rd_word[MACRO_WIDTH-1:WIDTH+1];
  end
`else
  logic spare_unused;
  assign spare_unused = ^rd_word[MACRO_WIDTH-1:WIDTH];
  assign par_err      = 1'b0;
`endif

endmodule
